// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One radix-2 step per cycle; signs are applied in a final fix-up cycle.
module mul_div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_con_Start,
  input  logic [2:0]        i_con_MduCtrl,
  input  logic [DATA_W-1:0] i_data_A,
  input  logic [DATA_W-1:0] i_data_B,
  output logic [DATA_W-1:0] o_data_Hi,
  output logic [DATA_W-1:0] o_data_Lo,
  output logic              o_con_Busy,
  output logic              o_con_Done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned PW    = 2 * DATA_W;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [DATA_W-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic                is_div_q, is_div_d, is_signed_q, is_signed_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic [DATA_W:0]     mul_sum, div_sh, div_diff;
  logic [PW-1:0]       prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, a_orig;
  logic                op_signed;

  // Next-state, datapath step and result write-back
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    op_signed = ~i_con_MduCtrl[0];
    mul_sum   = {1'b0, acc_q[PW-1:DATA_W]} + (acc_q[0] ? {1'b0, mag_a_q} : (DATA_W+1)'(0));
    div_sh    = {acc_q[PW-1:DATA_W], acc_q[DATA_W-1]};
    div_diff  = div_sh - {1'b0, mag_b_q};
    prod_fix  = (is_signed_q && (sign_a_q ^ sign_b_q)) ? PW'(0) - acc_q : acc_q;
    quo_fix   = (is_signed_q && (sign_a_q ^ sign_b_q)) ? DATA_W'(0) - acc_q[DATA_W-1:0]
                                                       : acc_q[DATA_W-1:0];
    rem_fix   = (is_signed_q && sign_a_q) ? DATA_W'(0) - acc_q[PW-1:DATA_W]
                                          : acc_q[PW-1:DATA_W];
    a_orig    = sign_a_q ? DATA_W'(0) - mag_a_q : mag_a_q;

    case (state_q)
      IDLE: begin
        if (i_con_Start) begin
          case (i_con_MduCtrl)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              sign_a_d    = op_signed & i_data_A[DATA_W-1];
              sign_b_d    = op_signed & i_data_B[DATA_W-1];
              mag_a_d     = sign_a_d ? DATA_W'(0) - i_data_A : i_data_A;
              mag_b_d     = sign_b_d ? DATA_W'(0) - i_data_B : i_data_B;
              is_div_d    = i_con_MduCtrl[1];
              is_signed_d = op_signed;
              // Multiply seeds the multiplier, divide seeds the dividend, in the low half
              acc_d       = i_con_MduCtrl[1] ? {DATA_W'(0), mag_a_d} : {DATA_W'(0), mag_b_d};
              cnt_d       = '0;
              busy_d      = 1'b1;
              state_d     = CALC;
            end
            OP_MTHI: hi_d = i_data_A;
            OP_MTLO: lo_d = i_data_A;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (is_div_q) begin
          if (!div_diff[DATA_W]) acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
          else                   acc_d = {div_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIX;
      end
      FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[PW-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end else if (mag_b_q == '0) begin
          hi_d = a_orig;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_data_Hi  = hi_q;
  assign o_data_Lo  = lo_q;
  assign o_con_Busy = busy_q;
  assign o_con_Done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver pushes model results, monitor pops on Done.
module tb_mul_div_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_con_Start;
  logic [2:0]  i_con_MduCtrl;
  logic [31:0] i_data_A, i_data_B;
  logic [31:0] o_data_Hi, o_data_Lo;
  logic        o_con_Busy, o_con_Done;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] model_hi, model_lo;
  logic        prev_done;

  mul_div_unit #(.DATA_W(32)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_con_Start   (i_con_Start),
    .i_con_MduCtrl (i_con_MduCtrl),
    .i_data_A      (i_data_A),
    .i_data_B      (i_data_B),
    .o_data_Hi     (o_data_Hi),
    .o_data_Lo     (o_data_Lo),
    .o_con_Busy    (o_con_Busy),
    .o_con_Done    (o_con_Done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: {HI, LO} from plain arithmetic on the architectural rules
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: results on Done, HI/LO hold while Busy
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_con_Done) begin
        check("done_single_cycle", 64'(prev_done), 64'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: actual=1 required=0 at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("result_hi_lo", {o_data_Hi, o_data_Lo}, mon_e);
          model_hi = mon_e[63:32];
          model_lo = mon_e[31:0];
        end
      end else if (o_con_Busy) begin
        check("hold_hi_lo", {o_data_Hi, o_data_Lo}, {model_hi, model_lo});
      end
      prev_done = o_con_Done;
    end
  end

  // Issue one Start; called right after a falling edge
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_con_Start   = 1'b1;
    i_con_MduCtrl = op;
    i_data_A      = a;
    i_data_B      = b;
    @(negedge i_clk);
    i_con_Start   = 1'b0;
    i_con_MduCtrl = 3'($urandom_range(0, 7));
    i_data_A      = $urandom;
    i_data_B      = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!o_con_Done && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_con_Done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: actual=no_done required=done within 200 cycles");
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    exp_q.push_back(ref_model(op, a, b));
    start_op(op, a, b);
    check("busy_after_start", 64'(o_con_Busy), 64'd1);
    wait_done(n);
    check("latency", 64'(n), 64'd33);
  endtask

  task automatic move_op(input logic [2:0] op, input logic [31:0] a);
    start_op(op, a, $urandom);
    if (op == 3'd4) model_hi = a;
    else            model_lo = a;
    check("move_busy_done", {62'd0, o_con_Busy, o_con_Done}, 64'd0);
    check("move_hi_lo", {o_data_Hi, o_data_Lo}, {model_hi, model_lo});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [2:0]  op;
    logic [31:0] a, b;

    i_rst = 1'b1; i_con_Start = 1'b0; i_con_MduCtrl = '0; i_data_A = '0; i_data_B = '0;
    model_hi = '0; model_lo = '0; prev_done = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_hi_lo", {o_data_Hi, o_data_Lo}, 64'd0);
    check("reset_busy_done", {62'd0, o_con_Busy, o_con_Done}, 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {o_data_Hi, o_data_Lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge i_clk);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg", {o_data_Hi, o_data_Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg", {o_data_Hi, o_data_Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd100, 32'd0);
    check("divu_zero", {o_data_Hi, o_data_Lo}, {32'd100, 32'hFFFF_FFFF});
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {o_data_Hi, o_data_Lo}, {32'd0, 32'h8000_0000});
    @(negedge i_clk);

    move_op(3'd4, 32'h1234_5678);
    move_op(3'd5, 32'hCAFE_F00D);

    // Start while busy must be ignored; HI keeps 0x12345678 until Done
    exp_q.push_back(ref_model(3'd3, 32'd17, 32'd5));
    start_op(3'd3, 32'd17, 32'd5);
    repeat (5) @(negedge i_clk);
    start_op(3'd4, 32'hDEAD_BEEF, 32'd0);
    wait_done(n);
    check("latency_mid_start", 64'(n + 6), 64'd33);
    check("divu_17_5", {o_data_Hi, o_data_Lo}, {32'd2, 32'd3});
    @(negedge i_clk);

    start_op(3'd6, 32'hAAAA_AAAA, 32'h5555_5555);
    check("reserved6", {o_data_Hi, o_data_Lo, 31'd0, o_con_Busy}, {model_hi, model_lo, 32'd0});
    start_op(3'd7, 32'h1111_1111, 32'h2222_2222);
    check("reserved7", {o_data_Hi, o_data_Lo, 31'd0, o_con_Busy}, {model_hi, model_lo, 32'd0});

    // Asynchronous reset mid-operation aborts without writing
    start_op(3'd1, 32'd3, 32'd4);
    repeat (9) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("async_reset_hi_lo", {o_data_Hi, o_data_Lo}, 64'd0);
    check("async_reset_busy_done", {62'd0, o_con_Busy, o_con_Done}, 64'd0);
    model_hi = '0; model_lo = '0; prev_done = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    run_op(3'd1, 32'd5, 32'd6);
    check("multu_5_6", {o_data_Hi, o_data_Lo}, 64'd30);
    run_op(3'd3, 32'd9, 32'd2);
    check("divu_9_2", {o_data_Hi, o_data_Lo}, {32'd1, 32'd4});

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = -32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(op, a, b);
      if ($urandom_range(0, 3) == 0) move_op(3'($urandom_range(4, 5)), $urandom);
      if ($urandom_range(0, 1) == 0) @(negedge i_clk);
    end

    repeat (3) @(negedge i_clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit that owns the MIPS HI/LO registers.
- Execute stage issues a request (opcode + operands); the unit computes over multiple cycles and signals completion.
- Covers mult, multu, div, divu, mthi and mtlo. HI/LO values are always visible on the outputs for mfhi/mflo selection in the execute stage.
- Complements the single-cycle ALU for the long-latency operations it cannot perform.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_con_Start  input  1  request strobe, sampled on rising edge
i_con_MduCtrl  input  3  opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
i_data_A  input  DATA_W  rs operand (multiplicand / dividend / mthi-mtlo source)
i_data_B  input  DATA_W  rt operand (multiplier / divisor)
o_data_Hi  output  DATA_W  HI register
o_data_Lo  output  DATA_W  LO register
o_con_Busy  output  1  operation in progress; new starts ignored
o_con_Done  output  1  one-cycle pulse, HI/LO just updated by mult/div

Behaviour:
- Reset (async, any time, including mid-operation):
  - HI=0, LO=0, Busy=0, Done=0, state IDLE, counter 0.
  - Any in-flight operation is aborted with no partial write.
- States: IDLE, CALC, FIX.
- IDLE:
  - Start accepted only when Busy=0.
  - On accept of op 0-3 (edge E0): latch operand magnitudes and sign flags, counter=0, go to CALC. Busy=1 from E0.
  - Signed ops (0, 2) take the two's-complement magnitude of A and B. Unsigned ops (1, 3) use the raw values.
- CALC:
  - One radix-2 step per edge, E1..E32.
  - Multiply is shift-add into a 2*DATA_W product. Divide is restoring shift-subtract, producing quotient and remainder.
  - At counter = DATA_W-1 the state goes to FIX on that edge (E32).
- FIX, at edge E33:
  - Apply signs: the product is negated if sA^sB (signed mult); the quotient is negated if sA^sB and the remainder is negated if sA (signed div).
  - Write HI/LO, go to IDLE, Busy=0, Done=1 for the single cycle following E33.
- Latency: the result is visible on HI/LO DATA_W+1 edges after the accepting edge. Busy falls and Done rises on the same edge.
- Result mapping:
  - mult/multu: HI = product[2W-1:W], LO = product[W-1:0].
  - div/divu: LO = quotient, HI = remainder.
- Divide by zero (B=0, signed or unsigned): LO = all ones, HI = A (unmodified dividend). This is deterministic, with no trap.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO (op 4/5) with Start in IDLE: HI (or LO) = A on that edge. No Busy, no Done. The other register is unchanged.
- Reserved ops 6-7: ignored, with no state change.
- Start while Busy=1: ignored. Operands are not re-sampled and the in-flight operation continues undisturbed.
- Start during the Done cycle is legal (state IDLE) and is accepted normally.
- HI/LO hold their old values throughout CALC/FIX until the E33 write.
- Operand inputs may change freely after the accepting edge.
- All outputs come directly from registers, with no combinational paths from inputs.

Test Plan:
- Reset with HI=LO=0, Busy=0 → MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → Busy for 33 cycles, Done pulse once; HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21); then DIV A=-7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU A=100, B=0 → LO=0xFFFFFFFF, HI=100.
- DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI A=0x12345678, then MTLO A=0xCAFEF00D on consecutive cycles → HI/LO updated next edge, Busy/Done never asserted. Then DIVU 17/5, with a MTHI Start issued mid-CALC → ignored; final LO=3, HI=2, and HI shows 0x12345678 until the Done edge.
- Start MULTU 3*4 and assert i_rst asynchronously at cycle 10 → Busy/Done/HI/LO=0 immediately. After release, a Done-cycle back-to-back Start (MULTU 5*6 then DIVU 9/2) gives LO=30, then LO=4, HI=1.
